// File: rtl/branch_seq_ctrl.sv
// rtl/branch_seq_ctrl.sv - conditional-branch sequencer using the shared ALU zero flag
// Optional taken/not-taken statistics counters: define BRANCH_SEQ_STATS_EN.
module branch_seq_ctrl #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [1:0]      alu_op,
    input  logic            alu_done,
    input  logic            alu_zero,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_illegal,
    output logic            res_misalign,
    output logic            res_timeout,
`ifdef BRANCH_SEQ_STATS_EN
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_not_taken,
`endif
    input  logic            abort
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_REDIR,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_target;
    logic [CW-1:0]   r_cnt;
    logic            r_taken;
    logic            r_illegal;
    logic            r_misalign;
    logic            r_timeout;
    logic            w_accept;
    logic            w_br_illegal;
    logic            w_taken;
    logic            w_cnt_max;

    assign w_accept     = br_valid && (r_state == S_IDLE) && !abort;
    assign w_br_illegal = (br_funct3[2:1] == 2'b01);
    assign w_cnt_max    = (r_cnt == CNT_MAX);

    // SLT/SLTU produce 1 when less-than, so "less" branches take on a non-zero result.
    always_comb begin
        w_taken = 1'b0;
        case (r_funct3)
            3'b000:  w_taken = alu_zero;
            3'b001:  w_taken = !alu_zero;
            3'b100:  w_taken = !alu_zero;
            3'b101:  w_taken = alu_zero;
            3'b110:  w_taken = !alu_zero;
            3'b111:  w_taken = alu_zero;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        br_ready       = (r_state == S_IDLE);
        alu_req        = (r_state == S_REQ);
        redirect_valid = (r_state == S_REDIR);
        redirect_pc    = r_target;
        flush          = (r_state == S_REDIR) && redirect_ready && !abort;
        res_valid      = (r_state == S_RESP) && !abort;
        res_taken      = res_valid && r_taken;
        res_illegal    = res_valid && r_illegal;
        res_misalign   = res_valid && r_misalign;
        res_timeout    = res_valid && r_timeout;
        alu_op         = !r_funct3[2] ? 2'b00 : (!r_funct3[1] ? 2'b01 : 2'b10);
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_br_illegal ? S_RESP : S_REQ;
            S_REQ:   if (alu_gnt) w_next = S_WAIT;
            S_WAIT: begin
                if (alu_done)       w_next = (w_taken && !r_target[1]) ? S_REDIR : S_RESP;
                else if (w_cnt_max) w_next = S_RESP;
            end
            S_REDIR: if (redirect_ready) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3   <= 3'b000;
            r_target   <= '0;
            r_cnt      <= '0;
            r_taken    <= 1'b0;
            r_illegal  <= 1'b0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3   <= br_funct3;
                r_target   <= br_pc + br_imm;
                r_illegal  <= w_br_illegal;
                r_taken    <= 1'b0;
                r_misalign <= 1'b0;
                r_timeout  <= 1'b0;
            end
            if (r_state == S_REQ && alu_gnt) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (alu_done) begin
                    r_taken    <= w_taken;
                    r_misalign <= w_taken && r_target[1];
                end else if (w_cnt_max) begin
                    r_timeout  <= 1'b1;
                end
            end
        end
    end

`ifdef BRANCH_SEQ_STATS_EN
    // Only clean resolutions are counted; faulted results land in neither counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
        end else if (res_valid && !r_illegal && !r_misalign && !r_timeout) begin
            if (r_taken) begin
                if (stat_taken != 32'hFFFF_FFFF) stat_taken <= stat_taken + 32'd1;
            end else begin
                if (stat_not_taken != 32'hFFFF_FFFF) stat_not_taken <= stat_not_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
Multi-cycle sequencer that resolves conditional branches (funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU) using the shared integer ALU and its zero flag.
- Accepts one branch from decode and requests the ALU for a compare.
- Decides taken or not-taken from alu_zero, then issues a PC redirect plus pipeline flush to fetch when taken.
- Sits between decode, the ALU arbiter and the fetch unit.

Parameters:
XLEN, 32, datapath and PC width
MAX_WAIT, 15, max cycles from ALU grant to alu_done before a timeout error; counter width is clog2(MAX_WAIT+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
br_valid  in  1  decode presents a branch
br_ready  out  1  controller can accept (high only in IDLE)
br_funct3  in  3  instruction funct3
br_pc  in  XLEN  branch instruction PC
br_imm  in  XLEN  sign-extended B-immediate
alu_req  out  1  request for shared ALU
alu_gnt  in  1  arbiter grant
alu_op  out  2  00 SUB, 01 SLT, 10 SLTU
alu_done  in  1  ALU result valid (single-cycle pulse)
alu_zero  in  1  ALU result == 0, sampled when alu_done=1
redirect_valid  out  1  fetch redirect request
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  XLEN  branch target
flush  out  1  one-cycle pulse on redirect handshake
res_valid  out  1  one-cycle pulse: branch resolved
res_taken  out  1  resolution outcome, valid with res_valid
res_illegal  out  1  funct3 010/011; valid with res_valid
res_misalign  out  1  taken target with bit[1]=1; valid with res_valid
res_timeout  out  1  ALU did not respond; valid with res_valid
abort  in  1  synchronous kill from the trap/flush logic

Behaviour:
- Reset: state=IDLE; all outputs 0 except br_ready=1; internal registers cleared.
- Accept: br_valid & br_ready in IDLE. Latch funct3, target = br_pc + br_imm (mod 2^XLEN, carry dropped).
- Op select: EQ/NE -> SUB; LT/GE -> SLT; LTU/GEU -> SLTU.
- Illegal funct3 (010, 011): go straight to RESP with res_illegal=1, res_taken=0; no ALU request.
- States:
  - IDLE -> REQ on accept.
  - REQ: alu_req=1 and alu_op stable until alu_gnt. Grant may arrive in the same cycle as the request; on grant -> WAIT and clear wait_cnt.
  - WAIT: alu_req=0; wait_cnt increments each cycle.
    - alu_done -> compute taken.
    - wait_cnt==MAX_WAIT without alu_done -> RESP with res_timeout=1, taken=0.
  - Taken rule, zero = alu_zero:
    - EQ: zero
    - NE: !zero
    - LT: !zero
    - GE: zero
    - LTU: !zero
    - GEU: zero
  - Not taken -> RESP. Taken with target[1]=1 -> RESP with res_misalign=1 and no redirect. Taken otherwise -> REDIR.
  - REDIR: redirect_valid=1, redirect_pc=target, held stable until redirect_ready. On handshake, flush=1 for that cycle and -> RESP.
  - RESP: res_valid=1 for one cycle with flags -> IDLE.
- Latency, best case with grant and done immediate:
  - Accept cycle N: REQ at N+1, WAIT at N+2.
  - alu_done at N+2: res_valid at N+3 if not taken; redirect_valid at N+3 if taken.
- No new branch is accepted until back in IDLE, so no back-to-back overlap.
- abort, highest priority in any state:
  - Next state IDLE.
  - Deasserts alu_req/redirect_valid the following cycle.
  - No res_valid, no flush.
  - An alu_done arriving after abort is ignored.
- abort together with accept in IDLE: the accept is dropped.
- alu_done outside WAIT is ignored.
- Asynchronous reset mid-operation returns to IDLE immediately; outputs go to reset values.

Optional Feature:
BRANCH_SEQ_STATS_EN. When defined, add outputs stat_taken and stat_not_taken, each 32-bit saturating counters.
- Increment on res_valid with taken / not-taken.
- Illegal, misalign and timeout results count in neither.
- Cleared by rst_n only.
Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- BEQ, pc=0x100, imm=0x20, gnt and done immediate, alu_zero=1 -> alu_op=00; redirect_valid at accept+3 with redirect_pc=0x120; flush pulse on ready; res_taken=1.
- BLTU, alu_zero=1 -> alu_op=10; no redirect; res_valid at accept+3 with res_taken=0.
- BNE, gnt delayed 4 cycles, redirect_ready delayed 3 cycles -> alu_req and redirect_pc stable throughout; exactly one flush pulse; res_taken=1.
- funct3=010 -> no alu_req; res_valid with res_illegal=1 at accept+1.
- BGE, alu_zero=1, pc=0xFFFFFFFC, imm=0x6 -> target 0x2 (wrap), bit1=1 -> res_misalign=1, no redirect_valid.
- Grant, then no alu_done for MAX_WAIT=15 cycles -> res_timeout=1; then abort asserted during REQ of the next branch -> IDLE the next cycle, no res_valid, br_ready=1.
